// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one byte-wide UART TX core between NUM_SRC packet
// sources and a periodic "OK\r\n" heartbeat. Arbitration is round-robin per
// packet; the heartbeat is only inserted between packets.
//
// Handshakes: a byte moves on a valid/ready pair only in a cycle where both are
// high at the rising clock edge. A producer holds valid and data stable until
// it sees ready. Ready never depends on the same port's valid.
//
// GAP_TIMEOUT_CYC is expected to be at least 1.
module uart_tx_scheduler #(
  parameter int          NUM_SRC         = 4,
  parameter logic [31:0] HB_PERIOD_CYC   = 32'd1_000_000_000,
  parameter logic [31:0] GAP_TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 hb_sent,
  output logic                 pkt_abort,
  output logic [7:0]           pkt_count,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HB   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_INIT = 3'(NUM_SRC - 1);

  state_t      state;
  logic [2:0]  last_grant;
  logic [31:0] hb_cnt;
  logic [31:0] gap_cnt;
  logic        hb_pending;
  logic [1:0]  hb_idx;

  logic        buf_free;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;
  logic        xfer_fire;
  logic        pick_any;
  logic [2:0]  pick_id;
  logic [7:0]  hb_byte;
  logic        hb_wrap;

  // The output register can take a new byte when empty or being drained.
  assign buf_free  = !tx_valid || tx_ready;
  assign busy      = (state != IDLE);
  assign fsm_state = state;
  assign xfer_fire = (state == XFER) && sel_valid && buf_free;
  assign hb_wrap   = (HB_PERIOD_CYC != 32'd0) && (hb_cnt == HB_PERIOD_CYC - 32'd1);

  // Route the granted source's handshake and payload.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == i[2:0]) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[8*i +: 8];
      end
    end
  end

  // Only the granted source sees ready, and only while in a packet.
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state == XFER && grant_id == i[2:0]) src_ready[i] = buf_free;
    end
  end

  // Round-robin pick: scan from last_grant+1 upward; scanning backwards lets
  // the first requester in search order overwrite the others.
  always_comb begin : arb
    int idx;
    idx      = 0;
    pick_any = 1'b0;
    pick_id  = 3'd0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_SRC;
      if (src_valid[idx]) begin
        pick_any = 1'b1;
        pick_id  = 3'(idx);
      end
    end
  end

  // Heartbeat message "OK\r\n".
  always_comb begin
    case (hb_idx)
      2'd0:    hb_byte = 8'h4F;
      2'd1:    hb_byte = 8'h4B;
      2'd2:    hb_byte = 8'h0D;
      default: hb_byte = 8'h0A;
    endcase
  end

  // Control FSM, output buffer, heartbeat timer and gap timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LAST_INIT;
      grant_id   <= 3'd0;
      hb_cnt     <= 32'd0;
      gap_cnt    <= 32'd0;
      hb_pending <= 1'b0;
      hb_idx     <= 2'd0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      hb_sent    <= 1'b0;
      pkt_abort  <= 1'b0;
      pkt_count  <= 8'd0;
    end else begin
      hb_sent   <= 1'b0;
      pkt_abort <= 1'b0;
      if (tx_valid && tx_ready) tx_valid <= 1'b0;

      if (HB_PERIOD_CYC != 32'd0) begin
        if (hb_wrap) hb_cnt <= 32'd0;
        else         hb_cnt <= hb_cnt + 32'd1;
      end
      // Sticky until the FSM enters HB, which happens from IDLE whenever set.
      hb_pending <= hb_wrap || (hb_pending && state != IDLE);

      case (state)
        IDLE: begin
          if (hb_pending) begin
            hb_idx <= 2'd0;
            state  <= HB;
          end else if (pick_any) begin
            grant_id <= pick_id;
            gap_cnt  <= 32'd0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (xfer_fire) begin
            tx_valid <= 1'b1;
            tx_data  <= sel_data;
            gap_cnt  <= 32'd0;
            if (sel_last) begin
              pkt_count  <= pkt_count + 8'd1;
              last_grant <= grant_id;
              state      <= IDLE;
            end
          end else if (gap_cnt >= GAP_TIMEOUT_CYC - 32'd1) begin
            pkt_abort  <= 1'b1;
            last_grant <= grant_id;
            state      <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        HB: begin
          if (buf_free) begin
            tx_valid <= 1'b1;
            tx_data  <= hb_byte;
            if (hb_idx == 2'd3) begin
              hb_sent <= 1'b1;
              state   <= IDLE;
            end else begin
              hb_idx <= hb_idx + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a short heartbeat period and gap
// timeout so both appear within a few dozen cycles.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src_valid = '0;
  logic [31:0] src_data = '0;
  logic [3:0]  src_last = '0;
  logic [3:0]  src_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [2:0]  grant_id;
  logic        busy;
  logic        hb_sent;
  logic        pkt_abort;
  logic [7:0]  pkt_count;
  logic [1:0]  fsm_state;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] src_q [4][$];   // {last, data} per source
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  logic [2:0] grant_q [$];
  int         hb_pulses = 0;
  int         abort_pulses = 0;
  logic [1:0] prev_state = 2'd0;
  logic [3:0] fire = '0;

  uart_tx_scheduler #(
    .NUM_SRC(4),
    .HB_PERIOD_CYC(32'd50),
    .GAP_TIMEOUT_CYC(32'd8)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .hb_sent(hb_sent),
    .pkt_abort(pkt_abort), .pkt_count(pkt_count), .fsm_state(fsm_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Source driver: presents the head of each source queue, pops on handshake.
  always begin
    @(negedge clk);
    fire = src_valid & src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        src_valid[i]        = 1'b1;
        src_data[8*i +: 8]  = src_q[i][0][7:0];
        src_last[i]         = src_q[i][0][8];
      end else begin
        src_valid[i]        = 1'b0;
        src_data[8*i +: 8]  = 8'h00;
        src_last[i]         = 1'b0;
      end
    end
  end

  // Monitor: delivered bytes, grants and pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) obs_q.push_back(tx_data);
      if (fsm_state == 2'd1 && prev_state != 2'd1) grant_q.push_back(grant_id);
      if (hb_sent) hb_pulses++;
      if (pkt_abort) abort_pulses++;
    end
    prev_state = fsm_state;
  end

  task automatic clear_scoreboard();
    for (int i = 0; i < 4; i++) src_q[i].delete();
    obs_q.delete();
    exp_q.delete();
    grant_q.delete();
    hb_pulses = 0;
    abort_pulses = 0;
  endtask

  // Returns just after rst deasserts (posedge + 2).
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    tx_ready = 1'b1;
    clear_scoreboard();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (tx_valid !== 1'b0)   begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    n_vec++; if (tx_data !== 8'h00)   begin n_err++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    n_vec++; if (grant_id !== 3'd0)   begin n_err++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (hb_sent !== 1'b0)    begin n_err++; $display("FAIL reset_hb_sent got %b want 0", hb_sent); end
    n_vec++; if (pkt_abort !== 1'b0)  begin n_err++; $display("FAIL reset_pkt_abort got %b want 0", pkt_abort); end
    n_vec++; if (pkt_count !== 8'd0)  begin n_err++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
    n_vec++; if (src_ready !== 4'h0)  begin n_err++; $display("FAIL reset_src_ready got %b want 0000", src_ready); end
    n_vec++; if (fsm_state !== 2'd0)  begin n_err++; $display("FAIL reset_state got %0d want 0", fsm_state); end
  endtask

  task automatic test_two_sources();
    do_reset();
    src_q[0] = '{9'h001, 9'h002, 9'h103};
    src_q[2] = '{9'h021, 9'h022, 9'h123};
    repeat (25) @(posedge clk);
    #2;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h21, 8'h22, 8'h23};
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL two_src_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL two_src_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (pkt_count !== 8'd2) begin n_err++; $display("FAIL two_src_pkt_count got %0d want 2", pkt_count); end
    n_vec++; if (grant_q.size() !== 2) begin n_err++; $display("FAIL two_src_grants got %0d want 2", grant_q.size()); end
    else begin
      n_vec++; if (grant_q[0] !== 3'd0) begin n_err++; $display("FAIL two_src_grant0 got %0d want 0", grant_q[0]); end
      n_vec++; if (grant_q[1] !== 3'd2) begin n_err++; $display("FAIL two_src_grant1 got %0d want 2", grant_q[1]); end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [$];
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        src_q[i].push_back({1'b1, 8'(8'h10 * (i + 1) + k)});
    repeat (30) @(posedge clk);
    #2;
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11, 8'h21, 8'h31, 8'h41};
    exp_g = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rr_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rr_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (grant_q.size() !== exp_g.size()) begin n_err++; $display("FAIL rr_grants got %0d want %0d", grant_q.size(), exp_g.size()); end
    for (int i = 0; i < exp_g.size() && i < grant_q.size(); i++) begin
      n_vec++; if (grant_q[i] !== exp_g[i]) begin n_err++; $display("FAIL rr_grant%0d got %0d want %0d", i, grant_q[i], exp_g[i]); end
    end
    n_vec++; if (pkt_count !== 8'd8) begin n_err++; $display("FAIL rr_pkt_count got %0d want 8", pkt_count); end
  endtask

  task automatic test_stall();
    logic [3:0] exp_rdy [4];
    logic [7:0] held;
    int stalls;
    logic prev_stall;
    exp_rdy = '{4'b0010, 4'b0000, 4'b0000, 4'b0010};
    stalls = 0;
    prev_stall = 1'b0;
    held = 8'h00;
    do_reset();
    src_q[1] = '{9'h0B0, 9'h0B1, 9'h0B2, 9'h1B3};
    // Grant lands at cycle 1, first byte is buffered from cycle 2; stall it two cycles.
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #2;
      tx_ready = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        n_vec++; if (src_ready !== exp_rdy[c-1]) begin n_err++; $display("FAIL stall_src_ready_c%0d got %b want %b", c, src_ready, exp_rdy[c-1]); end
      end
      if (tx_valid && !tx_ready) begin
        stalls++;
        n_vec++; if (tx_data !== 8'hB0) begin n_err++; $display("FAIL stall_data_c%0d got %h want b0", c, tx_data); end
        if (prev_stall) begin
          n_vec++; if (tx_data !== held) begin n_err++; $display("FAIL stall_hold_c%0d got %h want %h", c, tx_data, held); end
        end
        held = tx_data;
      end
      prev_stall = tx_valid && !tx_ready;
    end
    tx_ready = 1'b1;
    n_vec++; if (stalls !== 2) begin n_err++; $display("FAIL stall_cycles got %0d want 2", stalls); end
    exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_heartbeat();
    do_reset();
    // Counter wraps 50 cycles after reset; this packet spans that point.
    repeat (44) @(posedge clk);
    #2;
    for (int k = 0; k < 10; k++) src_q[3].push_back({(k == 9), 8'(8'hE0 + k)});
    repeat (30) @(posedge clk);
    #2;
    exp_q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8, 8'hE9,
              8'h4F, 8'h4B, 8'h0D, 8'h0A};
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL hb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL hb_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (hb_pulses !== 1) begin n_err++; $display("FAIL hb_sent_pulses got %0d want 1", hb_pulses); end
    n_vec++; if (pkt_count !== 8'd1) begin n_err++; $display("FAIL hb_pkt_count got %0d want 1", pkt_count); end
  endtask

  task automatic test_gap_abort();
    int fire_c;
    int abort_c;
    fire_c = -1;
    abort_c = -1;
    do_reset();
    src_q[1] = '{9'h0C1};
    src_q[2] = '{9'h1D2};
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (src_valid[1] && src_ready[1]) fire_c = c;
      if (pkt_abort) begin
        abort_c = c;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL gap_busy_at_abort got %b want 0", busy); end
        n_vec++; if (pkt_count !== 8'd0) begin n_err++; $display("FAIL gap_pkt_count_at_abort got %0d want 0", pkt_count); end
      end
    end
    // Byte accepted in cycle n, eight idle cycles follow, pulse in cycle n+9.
    n_vec++; if (abort_c - fire_c !== 9 || fire_c < 0) begin n_err++; $display("FAIL gap_abort_delay got %0d want 9", abort_c - fire_c); end
    n_vec++; if (abort_pulses !== 1) begin n_err++; $display("FAIL gap_abort_pulses got %0d want 1", abort_pulses); end
    exp_q = '{8'hC1, 8'hD2};
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL gap_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL gap_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (grant_q.size() !== 2) begin n_err++; $display("FAIL gap_grants got %0d want 2", grant_q.size()); end
    else begin
      n_vec++; if (grant_q[1] !== 3'd2) begin n_err++; $display("FAIL gap_next_grant got %0d want 2", grant_q[1]); end
    end
    n_vec++; if (pkt_count !== 8'd1) begin n_err++; $display("FAIL gap_final_pkt_count got %0d want 1", pkt_count); end
  endtask

  task automatic test_reset_mid_hb();
    logic found;
    found = 1'b0;
    do_reset();
    src_q[0] = '{9'h155};   // leaves last_grant at 0 before the reset
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (tx_valid && tx_data == 8'h4B) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rst_hb_wait got no 4b byte want 4b within 100 cycles"); end
    #1;
    rst = 1'b1;
    #1;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_hb_tx_valid got %b want 0", tx_valid); end
    n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_hb_busy got %b want 0", busy); end
    repeat (2) @(posedge clk);
    #2;
    clear_scoreboard();
    rst = 1'b0;
    src_q[3] = '{9'h133};
    src_q[0] = '{9'h166};
    repeat (10) @(posedge clk);
    #2;
    n_vec++; if (grant_q.size() < 1 || grant_q[0] !== 3'd0) begin n_err++; $display("FAIL rst_hb_first_grant got %0d want 0", (grant_q.size() > 0) ? grant_q[0] : 3'd7); end
    n_vec++; if (obs_q.size() < 1 || obs_q[0] !== 8'h66) begin n_err++; $display("FAIL rst_hb_first_byte got %h want 66", (obs_q.size() > 0) ? obs_q[0] : 8'hxx); end
  endtask

  initial begin
    test_reset();
    test_two_sources();
    test_round_robin();
    test_stall();
    test_heartbeat();
    test_gap_abort();
    test_reset_mid_hb();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one byte-wide UART transmitter core between NUM_SRC packet sources and an internal heartbeat generator. Arbitration is round-robin at packet granularity: a grant is held from the first byte until the source's last byte. Every HB_PERIOD_CYC cycles the block inserts the fixed heartbeat message "OK\r\n", but only at a packet boundary. The block sits between the application byte producers and the UART TX serializer (valid/ready byte interface).

Parameters:
NUM_SRC, 4, number of packet sources (2..8)
HB_PERIOD_CYC, 1_000_000_000, heartbeat period in clk cycles (10 s at 100 MHz); 0 disables heartbeat
GAP_TIMEOUT_CYC, 1_000_000, max idle cycles inside a granted packet before abort

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
src_valid  in  NUM_SRC  per-source byte valid
src_data  in  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i]
src_last  in  NUM_SRC  marks final byte of packet
src_ready  out  NUM_SRC  per-source accept
tx_valid  out  1  byte valid to UART TX core
tx_data  out  8  byte to UART TX core
tx_ready  in  1  UART TX core accepts byte
grant_id  out  3  index of current/last granted source
busy  out  1  high in any state except IDLE
hb_sent  out  1  one-cycle pulse when last heartbeat byte is loaded
pkt_abort  out  1  one-cycle pulse on gap-timeout abort
pkt_count  out  8  completed source packets, wraps 255->0

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=NUM_SRC-1, so source 0 wins first; hb counter 0; hb_pending 0.
- Output buffer: a one-deep register holds tx_valid/tx_data. It is "free" when !tx_valid or tx_ready.
  - A byte loads into the buffer only when it is free.
  - When a byte is consumed (tx_valid & tx_ready) and no new byte is loaded, tx_valid drops to 0.
- Heartbeat counter: 32-bit, counts 0..HB_PERIOD_CYC-1 and wraps.
  - On the wrap it sets hb_pending.
  - hb_pending is sticky, does not queue multiple heartbeats, and clears on entry to HB.
  - The counter runs in every state.
- States IDLE, XFER, HB:
  - IDLE:
    - If hb_pending -> HB with hb_idx=0.
    - Else, if any src_valid, pick the first requester searching from (last_grant+1) mod NUM_SRC upward. Set grant_id to it -> XFER.
    - The decision takes one cycle; src_ready is all 0 in IDLE.
  - XFER:
    - src_ready[grant_id] = buffer free; all other src_ready bits are 0.
    - On src_valid&src_ready, load src_data into the buffer and reset the gap counter.
    - If that byte has src_last set: pkt_count++, last_grant=grant_id -> IDLE.
    - Each cycle without a transfer increments the gap counter.
    - When the gap counter reaches GAP_TIMEOUT_CYC: pulse pkt_abort, last_grant=grant_id, no pkt_count change -> IDLE. A byte already in the buffer is still delivered.
  - HB:
    - Loads 0x4F, 0x4B, 0x0D, 0x0A in order, one per free-buffer cycle.
    - hb_sent pulses in the cycle the 0x0A byte is loaded -> IDLE.
    - src_ready is all 0 in HB.
- Heartbeat never interrupts a packet. A wrap during XFER waits until the packet ends (last byte or abort).
- Latency: a byte accepted at cycle N appears on tx_valid at N+1. Sustained throughput is 1 byte/cycle when tx_ready is held high.
- A simultaneous src_last transfer and gap-timeout is impossible, because a transfer resets the gap counter; the last byte wins.
- src_valid on non-granted sources is ignored; no ready is issued to them. Sources must hold data while valid and not ready.
- tx_data must not change while tx_valid & !tx_ready.
- Reset mid-packet or mid-heartbeat: immediate return to the reset state; the buffered byte is discarded (tx_valid=0).
- pkt_count wraps silently.

Test Plan:
- Sources 0 and 2 each send a 3-byte packet concurrently, tx_ready=1 -> tx_data order src0 bytes then src2 bytes, no interleave; pkt_count=2; grant_id 0 then 2.
- Sources 0,1,2,3 all continuously request 1-byte packets -> grants 0,1,2,3,0,... with no source skipped.
- tx_ready toggled 1-0-0-1 during a 4-byte packet -> tx_data held stable while stalled; all 4 bytes delivered in order; src_ready mirrors buffer-free.
- HB_PERIOD_CYC=50, heartbeat wrap occurs mid-packet -> packet completes first, then 0x4F,0x4B,0x0D,0x0A; one hb_sent pulse.
- GAP_TIMEOUT_CYC=8, source 1 sends 1 byte, then drops valid without last -> pkt_abort pulse 8 cycles later, state IDLE, pkt_count unchanged, next grant goes to source 2 if it is requesting.
- rst asserted during the 2nd heartbeat byte -> tx_valid=0 and busy=0 immediately; after release, source 0 is granted first.
